sli_video_timing: RTL

Raster timing generator for the SLI projector output path. It produces pixel/line counters and the raw hsync, vsync, blank and data-enable strobes. Those strobes then go through the per-signal 1-bit delay stages, which align them with the pattern-pixel pipeline. It also tracks which structured-light pattern is being shown: a pattern index advances once per frame and a sequence-done pulse marks the end of each N_PAT-frame capture sequence.

---
 rtl/sli_video_timing.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/sli_video_timing.sv
`default_nettype none
// ============================================================================
// Module   : sli_video_timing
// Purpose  : Raster timing generator with structured-light pattern sequencing.
// Revision : 1.0 - initial release
// ============================================================================
module sli_video_timing #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int N_PAT    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        restart,
  output logic [11:0] hcount,
  output logic [11:0] vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        de,
  output logic        frame_start,
  output logic [3:0]  pat_idx,
  output logic        seq_done
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // 13-bit decode constants so a boundary equal to 4096 cannot alias to 0
  localparam logic [12:0] c_H_ACT   = 13'(H_ACTIVE);
  localparam logic [12:0] c_HS_BEG  = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] c_HS_END  = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] c_V_ACT   = 13'(V_ACTIVE);
  localparam logic [12:0] c_VS_BEG  = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] c_VS_END  = 13'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] c_H_LAST  = 12'(c_H_TOTAL - 1);
  localparam logic [11:0] c_V_LAST  = 12'(c_V_TOTAL - 1);
  localparam logic [3:0]  c_P_LAST  = 4'(N_PAT - 1);

  logic [11:0] r_hc;
  logic [11:0] r_vc;
  logic [3:0]  r_pat;

  logic [11:0] r_hcount;
  logic [11:0] r_vcount;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_blank;
  logic        r_de;
  logic        r_frame_start;
  logic [3:0]  r_pat_idx;
  logic        r_seq_done;

  logic [11:0] w_h;
  logic [11:0] w_v;
  logic [3:0]  w_p;
  logic [12:0] w_h13;
  logic [12:0] w_v13;
  logic        w_de;
  logic        w_hs_on;
  logic        w_vs_on;
  logic        w_fs;
  logic        w_seq;
  logic        w_h_last;
  logic        w_v_last;
  logic        w_p_last;
  logic [11:0] w_hc_nxt;
  logic [11:0] w_vc_nxt;
  logic [3:0]  w_pat_nxt;

  // Position to decode: restart presents (0,0) of pattern 0 on the same edge
  always_comb begin
    w_h   = restart ? 12'd0 : r_hc;
    w_v   = restart ? 12'd0 : r_vc;
    w_p   = restart ? 4'd0  : r_pat;
    w_h13 = {1'b0, w_h};
    w_v13 = {1'b0, w_v};

    w_de    = (w_h13 < c_H_ACT) && (w_v13 < c_V_ACT);
    w_hs_on = (w_h13 >= c_HS_BEG) && (w_h13 < c_HS_END);
    w_vs_on = (w_v13 >= c_VS_BEG) && (w_v13 < c_VS_END);
    w_fs    = (w_h == 12'd0) && (w_v == 12'd0);
    w_seq   = (w_h == c_H_LAST) && (w_v == c_V_LAST) && (w_p == c_P_LAST);
  end

  always_comb begin
    w_h_last  = (r_hc == c_H_LAST);
    w_v_last  = (r_vc == c_V_LAST);
    w_p_last  = (r_pat == c_P_LAST);
    w_hc_nxt  = w_h_last ? 12'd0 : r_hc + 12'd1;
    w_vc_nxt  = r_vc;
    w_pat_nxt = r_pat;
    if (w_h_last) begin
      w_vc_nxt = w_v_last ? 12'd0 : r_vc + 12'd1;
      if (w_v_last) begin
        w_pat_nxt = w_p_last ? 4'd0 : r_pat + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hc  <= 12'd0;
      r_vc  <= 12'd0;
      r_pat <= 4'd0;
    end else if (restart) begin
      r_hc  <= 12'd1;
      r_vc  <= 12'd0;
      r_pat <= 4'd0;
    end else if (en) begin
      r_hc  <= w_hc_nxt;
      r_vc  <= w_vc_nxt;
      r_pat <= w_pat_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hcount      <= 12'd0;
      r_vcount      <= 12'd0;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_blank       <= 1'b1;
      r_de          <= 1'b0;
      r_frame_start <= 1'b0;
      r_pat_idx     <= 4'd0;
      r_seq_done    <= 1'b0;
    end else if (restart || en) begin
      r_hcount      <= w_h;
      r_vcount      <= w_v;
      r_hsync       <= w_hs_on ? HS_POL : ~HS_POL;
      r_vsync       <= w_vs_on ? VS_POL : ~VS_POL;
      r_blank       <= ~w_de;
      r_de          <= w_de;
      r_frame_start <= w_fs;
      r_pat_idx     <= w_p;
      r_seq_done    <= w_seq;
    end
  end

  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign blank       = r_blank;
  assign de          = r_de;
  assign frame_start = r_frame_start;
  assign pat_idx     = r_pat_idx;
  assign seq_done    = r_seq_done;

endmodule
`default_nettype wire
